// File: rtl/mbm_pkg.sv
// Shared definitions for the multi-bank memory controller.
// Holds the default geometry, the derived field widths and an address
// decoder that splits an address into {bank, sub, idx}, MSB first.
package mbm_pkg;

  localparam int MBM_DATA_W    = 8;
  localparam int MBM_ADDR_W    = 11;
  localparam int MBM_BANKS     = 4;
  localparam int MBM_SUB_BANKS = 4;
  localparam int MBM_CNT_W     = 8;

  localparam int BANK_W = $clog2(MBM_BANKS);
  localparam int SUB_W  = $clog2(MBM_SUB_BANKS);
  localparam int IDX_W  = MBM_ADDR_W - BANK_W - SUB_W;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [SUB_W-1:0]  sub;
    logic [IDX_W-1:0]  idx;
  } mbm_addr_t;

  function automatic mbm_addr_t decode(input logic [MBM_ADDR_W-1:0] addr);
    mbm_addr_t d;
    d.bank = addr[MBM_ADDR_W-1 -: BANK_W];
    d.sub  = addr[MBM_ADDR_W-BANK_W-1 -: SUB_W];
    d.idx  = addr[IDX_W-1:0];
    return d;
  endfunction

endpackage

// File: rtl/mbm_sub_array.sv
// Single-port synchronous RAM used as one sub-array of the controller.
// One access per cycle: a write when we=1, otherwise a registered read.
// Contents and the read register are intentionally not reset.
module mbm_sub_array #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**IDX_W];

  // Storage access: write the word, or capture the addressed word for reading
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/multi_bank_memory_ctrl.sv
// Multi-bank memory controller: BANKS x SUB_BANKS single-port sub-arrays
// with one read and one write port. A write that collides with a read on
// the same sub-array is parked in a one-entry buffer (wready=0) and retires
// on the first cycle with no read to that sub-array.
// Optional feature macro: MBM_FWD_EN forwards buffered/colliding write data
// to a read of the identical address so reads always see the newest data.
module multi_bank_memory_ctrl
  import mbm_pkg::*;
#(
  parameter int DATA_W    = MBM_DATA_W,
  parameter int ADDR_W    = MBM_ADDR_W,
  parameter int BANKS     = MBM_BANKS,
  parameter int SUB_BANKS = MBM_SUB_BANKS,
  parameter int CNT_W     = MBM_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  output logic              wready,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Key = {bank, sub} selects the sub-array; idx addresses inside it.
  localparam int KW   = $clog2(BANKS) + $clog2(SUB_BANKS);
  localparam int IW   = ADDR_W - KW;
  localparam int NSUB = BANKS * SUB_BANKS;

  logic [KW-1:0]     rkey, wkey, pkey;
  logic [IW-1:0]     ridx, widx, pidx;

  logic              pend_v;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  logic              defer, new_wr, retire, wr_go;
  logic [KW-1:0]     wr_key;
  logic [IW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] rd_word [NSUB];
  logic [KW-1:0]     rsel_q;

  assign rkey = raddr[ADDR_W-1 -: KW];
  assign wkey = waddr[ADDR_W-1 -: KW];
  assign pkey = pend_addr[ADDR_W-1 -: KW];
  assign ridx = raddr[IW-1:0];
  assign widx = waddr[IW-1:0];
  assign pidx = pend_addr[IW-1:0];

  assign wready = !pend_v;

  // Read wins the sub-array; the pending write goes before any new write
  // because a new write is only accepted while the buffer is empty.
  assign defer  = wen && wready && ren && (rkey == wkey);
  assign new_wr = wen && wready && !defer;
  assign retire = pend_v && !(ren && (rkey == pkey));
  assign wr_go  = new_wr || retire;

  assign wr_key  = pend_v ? pkey      : wkey;
  assign wr_idx  = pend_v ? pidx      : widx;
  assign wr_data = pend_v ? pend_data : din;

  // One sub-array per {bank, sub}; a read and a write never share one here
  for (genvar s = 0; s < NSUB; s++) begin : g_sub
    logic sel_r, sel_w;
    assign sel_r = ren   && (rkey   == KW'(s));
    assign sel_w = wr_go && (wr_key == KW'(s));

    mbm_sub_array #(
      .DATA_W (DATA_W),
      .IDX_W  (IW)
    ) u_sub (
      .clk   (clk),
      .en    (sel_r || sel_w),
      .we    (sel_w && !sel_r),
      .addr  (sel_r ? ridx : wr_idx),
      .wdata (wr_data),
      .rdata (rd_word[s])
    );
  end

  // Deferred-write buffer: capture on a collision, clear when it retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (defer) begin
      pend_v    <= 1'b1;
      pend_addr <= waddr;
      pend_data <= din;
    end else if (retire) begin
      pend_v    <= 1'b0;
    end
  end

  // Saturating count of writes that had to be deferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (defer && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  // Read-side registers: validity and which sub-array supplies the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rsel_q <= '0;
    end else begin
      rvalid <= ren;
      rsel_q <= rkey;
    end
  end

`ifdef MBM_FWD_EN
  logic              fwd_hit, fwd_q;
  logic [DATA_W-1:0] fwd_data, fwd_data_q;

  // Buffered data and a colliding write are exclusive: defer needs an empty buffer
  assign fwd_hit  = ren && ((pend_v && (raddr == pend_addr)) ||
                            (defer  && (raddr == waddr)));
  assign fwd_data = pend_v ? pend_data : din;

  // Remember whether this read must return forwarded data instead of the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_hit;
      fwd_data_q <= fwd_data;
    end
  end

  assign dout = !rvalid ? '0 : (fwd_q ? fwd_data_q : rd_word[rsel_q]);
`else
  assign dout = rvalid ? rd_word[rsel_q] : '0;
`endif

endmodule
